video_layer_mixer: RTL and testbench
====================================

Name: video_layer_mixer

Overview:
- Parametrised N-layer pixel compositor that replaces the fixed two-way text/graphics output mux.
- Sits between the layer renderers (text, graphics, sprite/cursor) and the VGA DAC pins.
- Performs per-layer enable, transparency colour-key and priority selection, plus background fill, screen-edge border and brightness dimming.
- Delays sync and display-enable to match a fixed 3-cycle pipeline; all configuration is shadowed and commits atomically once per frame.

Parameters:
NUM_LAYERS, 2, number of input layers (1..8); layer 0 = lowest priority
COLOR_W, 12, bits per packed RGB pixel (3 equal channels; must be divisible by 3)
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SYNC_IDLE, 1, inactive level of hsync/vsync (negative-polarity syncs)

Ports:
video_clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
hcount  in  10  current pixel column from timing generator
vcount  in  10  current line from timing generator
hsync_in  in  1  horizontal sync from timing generator
vsync_in  in  1  vertical sync from timing generator
display_active  in  1  visible-region flag
layer_rgb  in  NUM_LAYERS*COLOR_W  packed layer pixels; layer i at [i*COLOR_W +: COLOR_W]
layer_valid  in  NUM_LAYERS  layer i drives a pixel this cycle
cfg_we  in  1  config write strobe (one write per cycle)
cfg_sel  in  4  config register select
cfg_data  in  COLOR_W  config write data
rgb_out  out  COLOR_W  composited pixel to DAC
hsync_out  out  1  hsync delayed 3 cycles
vsync_out  out  1  vsync delayed 3 cycles
de_out  out  1  display_active delayed 3 cycles
commit_pending  out  1  shadow config differs from the active config, awaiting the frame boundary
frame_count  out  16  commit-point counter, wraps at 16'hFFFF -> 0

Behaviour:
- Config registers (shadow), selected by cfg_sel:
  - 0 layer_en[NUM_LAYERS-1:0]
  - 1 key_en[NUM_LAYERS-1:0]
  - 2 bg_color
  - 3 border_color
  - 4 ctrl: bit0 border_en, bits2:1 dim
  - 8+i key_color[i]
- Upper data bits beyond a register's width are ignored. Writes to sel 5..7, or to 8+i with i>=NUM_LAYERS, are ignored, and commit_pending is unchanged.
- Commit point is the cycle with vcount==V_ACTIVE and hcount==0.
  - On that cycle: active <= shadow, commit_pending <= 0, frame_count increments.
  - A cfg write on the commit cycle updates shadow only. It is not committed this frame and leaves commit_pending=1.
- Any accepted write sets commit_pending=1, even if the data equals the current value.
- Reset values:
  - shadow and active: layer_en all ones, key_en 0, bg 0, border 0, ctrl 0.
  - rgb_out 0, de_out 0, hsync_out/vsync_out = SYNC_IDLE, commit_pending 0, frame_count 0.
  - All pipeline stages flush to these same values.
- Reset mid-frame drops in-flight pixels. Outputs show reset values for 3 cycles, then live data.
- Stage 1 (registered):
  - opaque[i] = layer_valid[i] & layer_en[i] & ~(key_en[i] & layer_rgb[i]==key_color[i]).
  - Also register the pixels, display_active, syncs, and edge.
  - edge = display_active & (hcount==0 | hcount==H_ACTIVE-1 | vcount==0 | vcount==V_ACTIVE-1).
- Stage 2 (registered): sel = highest-index opaque layer's pixel; if none is opaque, bg_color.
- Stage 3 (registered):
  - If !de then 0.
  - Else if border_en & edge then border_color; the border is not dimmed.
  - Else each channel of sel is logically right-shifted by dim (0..3).
- Latency: the pixel sampled at cycle t appears on rgb_out at t+3, together with its sync/de. Continuous throughput of one pixel per clock, no stalls.
- Config used in the pipeline is always the active copy, so no tearing mid-frame.

Test Plan:
- Reset then idle, NUM_LAYERS=2, layer0=12'h0F0 valid, layer1 invalid, display_active=1 -> rgb_out=0 for 3 cycles after reset release, then 12'h0F0; hsync_out equals hsync_in delayed exactly 3 cycles.
- Both layers valid: layer0=12'h00F, layer1=12'hF00 -> 12'hF00. Set key_en=2'b10 with key_color[1]=12'hF00 and commit -> 12'h00F. Set layer_en=0 -> bg_color (12'h123 after write) following the next commit.
- Write bg_color=12'hABC at vcount=100 -> commit_pending=1 and output unchanged; at vcount=480, hcount=0 -> active updated, commit_pending=0, frame_count+1, and 12'hABC seen from the next visible pixel.
- Write on the exact commit cycle -> not applied this frame; commit_pending stays 1 and the value applies at the following commit.
- border_en=1, border_color=12'hFFF, dim=2, layer pixel 12'hF84 -> edges (hcount 0/639, vcount 0/479) give 12'hFFF; interior gives 12'h321; display_active=0 gives 12'h000.
- Force frame_count to 16'hFFFF through repeated commits (or preload in sim) -> next commit gives 0. Assert reset mid-line -> all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/video_layer_mixer.sv
// N-layer pixel compositor: per-layer enable, colour-key, priority select,
// background fill, screen-edge border and dimming over a fixed 3-stage pipeline.
module video_layer_mixer #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned COLOR_W    = 12,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic        SYNC_IDLE  = 1'b1
) (
  input  logic                            video_clk,
  input  logic                            reset,
  input  logic [9:0]                      hcount,
  input  logic [9:0]                      vcount,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            display_active,
  input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]           layer_valid,
  input  logic                            cfg_we,
  input  logic [3:0]                      cfg_sel,
  input  logic [COLOR_W-1:0]              cfg_data,
  output logic [COLOR_W-1:0]              rgb_out,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic                            de_out,
  output logic                            commit_pending,
  output logic [15:0]                     frame_count
);

  localparam int unsigned CH_W  = COLOR_W / 3;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned FC_W  = 16;

  typedef struct packed {
    logic [NUM_LAYERS-1:0] layer_en;
    logic [NUM_LAYERS-1:0] key_en;
    logic [COLOR_W-1:0]    bg_color;
    logic [COLOR_W-1:0]    border_color;
    logic                  border_en;
    logic [1:0]            dim;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    layer_en:     '1,
    key_en:       '0,
    bg_color:     '0,
    border_color: '0,
    border_en:    1'b0,
    dim:          2'd0
  };

  cfg_t                                  shadow_q;
  cfg_t                                  active_q;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0]    shadow_key_q;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0]    active_key_q;

  logic [2:0]                            key_idx_c;
  logic                                  reg_we_c;
  logic                                  key_we_c;
  logic                                  cfg_accept_c;
  logic                                  commit_c;

  // Write decode and frame-boundary detect
  assign key_idx_c = cfg_sel[2:0];

  always_comb begin
    reg_we_c     = cfg_we && (cfg_sel <= 4'd4);
    key_we_c     = cfg_we && cfg_sel[3] && (32'(key_idx_c) < NUM_LAYERS);
    cfg_accept_c = reg_we_c || key_we_c;
    commit_c     = (hcount == '0) && (vcount == CNT_W'(V_ACTIVE));
  end

  // Shadow/active config; a write landing on the commit cycle waits a frame
  always_ff @(posedge video_clk) begin
    if (reset) begin
      shadow_q       <= CFG_RESET;
      active_q       <= CFG_RESET;
      shadow_key_q   <= '0;
      active_key_q   <= '0;
      commit_pending <= 1'b0;
      frame_count    <= '0;
    end else begin
      if (reg_we_c) begin
        case (cfg_sel)
          4'd0: shadow_q.layer_en     <= cfg_data[NUM_LAYERS-1:0];
          4'd1: shadow_q.key_en       <= cfg_data[NUM_LAYERS-1:0];
          4'd2: shadow_q.bg_color     <= cfg_data;
          4'd3: shadow_q.border_color <= cfg_data;
          4'd4: begin
            shadow_q.border_en <= cfg_data[0];
            shadow_q.dim       <= cfg_data[2:1];
          end
          default: ;
        endcase
      end
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (key_we_c && (key_idx_c == 3'(i))) shadow_key_q[i] <= cfg_data;
      end
      if (commit_c) begin
        active_q       <= shadow_q;
        active_key_q   <= shadow_key_q;
        frame_count    <= frame_count + FC_W'(1);
        commit_pending <= cfg_accept_c;
      end else if (cfg_accept_c) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Stage 1: opacity per layer and screen-edge flag
  logic [NUM_LAYERS-1:0]                 opaque_c;
  logic                                  on_edge_c;

  always_comb begin
    opaque_c = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque_c[i] = layer_valid[i] & active_q.layer_en[i] &
                    ~(active_q.key_en[i] &
                      (layer_rgb[i*COLOR_W +: COLOR_W] == active_key_q[i]));
    end
    on_edge_c = display_active &
                ((hcount == '0) || (hcount == CNT_W'(H_ACTIVE - 1)) ||
                 (vcount == '0) || (vcount == CNT_W'(V_ACTIVE - 1)));
  end

  logic [NUM_LAYERS-1:0][COLOR_W-1:0]    s1_rgb_q;
  logic [NUM_LAYERS-1:0]                 s1_opaque_q;
  logic                                  s1_de_q;
  logic                                  s1_hs_q;
  logic                                  s1_vs_q;
  logic                                  s1_edge_q;

  always_ff @(posedge video_clk) begin
    if (reset) begin
      s1_rgb_q    <= '0;
      s1_opaque_q <= '0;
      s1_de_q     <= 1'b0;
      s1_hs_q     <= SYNC_IDLE;
      s1_vs_q     <= SYNC_IDLE;
      s1_edge_q   <= 1'b0;
    end else begin
      s1_rgb_q    <= layer_rgb;
      s1_opaque_q <= opaque_c;
      s1_de_q     <= display_active;
      s1_hs_q     <= hsync_in;
      s1_vs_q     <= vsync_in;
      s1_edge_q   <= on_edge_c;
    end
  end

  // Stage 2: highest-index opaque layer wins, background otherwise
  logic [COLOR_W-1:0]                    sel_c;

  always_comb begin
    sel_c = active_q.bg_color;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s1_opaque_q[i]) sel_c = s1_rgb_q[i];
    end
  end

  logic [COLOR_W-1:0]                    s2_sel_q;
  logic                                  s2_de_q;
  logic                                  s2_hs_q;
  logic                                  s2_vs_q;
  logic                                  s2_edge_q;

  always_ff @(posedge video_clk) begin
    if (reset) begin
      s2_sel_q  <= '0;
      s2_de_q   <= 1'b0;
      s2_hs_q   <= SYNC_IDLE;
      s2_vs_q   <= SYNC_IDLE;
      s2_edge_q <= 1'b0;
    end else begin
      s2_sel_q  <= sel_c;
      s2_de_q   <= s1_de_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s2_edge_q <= s1_edge_q;
    end
  end

  // Stage 3: blanking, undimmed border, per-channel dimming
  logic [COLOR_W-1:0]                    dimmed_c;
  logic [COLOR_W-1:0]                    pix_c;

  always_comb begin
    dimmed_c = '0;
    for (int c = 0; c < 3; c++) begin
      dimmed_c[c*CH_W +: CH_W] = s2_sel_q[c*CH_W +: CH_W] >> active_q.dim;
    end
    if (!s2_de_q) begin
      pix_c = '0;
    end else if (active_q.border_en && s2_edge_q) begin
      pix_c = active_q.border_color;
    end else begin
      pix_c = dimmed_c;
    end
  end

  always_ff @(posedge video_clk) begin
    if (reset) begin
      rgb_out   <= '0;
      de_out    <= 1'b0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      rgb_out   <= pix_c;
      de_out    <= s2_de_q;
      hsync_out <= s2_hs_q;
      vsync_out <= s2_vs_q;
    end
  end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Bench for video_layer_mixer: directed literal checks plus randomized traffic
// compared every cycle against a frame-level behavioural model.
module tb_video_layer_mixer;

  localparam int NL = 2;
  localparam int CW = 12;

  logic                 video_clk = 1'b0;
  logic                 reset;
  logic [9:0]           hcount, vcount;
  logic                 hsync_in, vsync_in, display_active;
  logic [NL*CW-1:0]     layer_rgb;
  logic [NL-1:0]        layer_valid;
  logic                 cfg_we;
  logic [3:0]           cfg_sel;
  logic [CW-1:0]        cfg_data;
  logic [CW-1:0]        rgb_out;
  logic                 hsync_out, vsync_out, de_out, commit_pending;
  logic [15:0]          frame_count;

  video_layer_mixer dut (
    .video_clk      (video_clk),
    .reset          (reset),
    .hcount         (hcount),
    .vcount         (vcount),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .display_active (display_active),
    .layer_rgb      (layer_rgb),
    .layer_valid    (layer_valid),
    .cfg_we         (cfg_we),
    .cfg_sel        (cfg_sel),
    .cfg_data       (cfg_data),
    .rgb_out        (rgb_out),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .de_out         (de_out),
    .commit_pending (commit_pending),
    .frame_count    (frame_count)
  );

  always #5 video_clk = ~video_clk;

  typedef struct packed {
    logic [NL-1:0]          len;
    logic [NL-1:0]          ken;
    logic [CW-1:0]          bg;
    logic [CW-1:0]          bc;
    logic                   ben;
    logic [1:0]             dim;
    logic [NL-1:0][CW-1:0]  key;
  } mcfg_t;

  typedef struct packed {
    logic [9:0]             h;
    logic [9:0]             v;
    logic                   hs;
    logic                   vs;
    logic                   de;
    logic [NL-1:0]          vld;
    logic [NL-1:0][CW-1:0]  px;
  } msmp_t;

  int n_checks = 0;
  int n_pass   = 0;

  mcfg_t   sh, act;
  logic    pend;
  logic [15:0] fc;
  mcfg_t   cfg_h [3];
  msmp_t   smp_h [3];
  logic    rst_h [3];
  logic [CW-1:0] exp_rgb;
  logic [2:0]    exp_sync;
  logic          started = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
  endtask

  function automatic mcfg_t cfg_default();
    mcfg_t c;
    c = '0;
    c.len = '1;
    return c;
  endfunction

  // Expected pixel for one sample, given the active config seen by each pipeline step
  function automatic logic [CW-1:0] mix(msmp_t s, mcfg_t c1, mcfg_t c2, mcfg_t c3);
    logic [CW-1:0] sel;
    logic [CW-1:0] res;
    logic [3:0]    ch;
    logic          found;
    int            divisor;
    if (!s.de) return '0;
    if (c3.ben && (s.h == 10'd0 || s.h == 10'd639 || s.v == 10'd0 || s.v == 10'd479))
      return c3.bc;
    sel = c2.bg;
    found = 1'b0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (!found && s.vld[i] && c1.len[i] && !(c1.ken[i] && s.px[i] == c1.key[i])) begin
        sel = s.px[i];
        found = 1'b1;
      end
    end
    divisor = 1 << c3.dim;
    res = '0;
    for (int k = 0; k < 3; k++) begin
      ch = sel[k*4 +: 4];
      res[k*4 +: 4] = 4'(int'(ch) / divisor);
    end
    return res;
  endfunction

  task automatic model_step();
    msmp_t s;
    mcfg_t nsh;
    logic  acc, com;
    s.h = hcount; s.v = vcount; s.hs = hsync_in; s.vs = vsync_in;
    s.de = display_active; s.vld = layer_valid; s.px = layer_rgb;
    for (int k = 0; k < 2; k++) begin
      rst_h[k] = rst_h[k+1]; smp_h[k] = smp_h[k+1]; cfg_h[k] = cfg_h[k+1];
    end
    rst_h[2] = reset; smp_h[2] = s; cfg_h[2] = act;
    if (rst_h[0] || rst_h[1] || rst_h[2]) begin
      exp_rgb  = '0;
      exp_sync = 3'b110;
    end else begin
      exp_rgb  = mix(smp_h[0], cfg_h[0], cfg_h[1], cfg_h[2]);
      exp_sync = {smp_h[0].hs, smp_h[0].vs, smp_h[0].de};
    end
    if (reset) begin
      sh = cfg_default(); act = cfg_default(); pend = 1'b0; fc = '0;
    end else begin
      acc = cfg_we && (cfg_sel <= 4'd4 || (cfg_sel >= 4'd8 && int'(cfg_sel) - 8 < NL));
      com = (hcount == 10'd0) && (vcount == 10'd480);
      nsh = sh;
      if (acc) begin
        case (cfg_sel)
          4'd0: nsh.len = cfg_data[NL-1:0];
          4'd1: nsh.ken = cfg_data[NL-1:0];
          4'd2: nsh.bg  = cfg_data;
          4'd3: nsh.bc  = cfg_data;
          4'd4: begin nsh.ben = cfg_data[0]; nsh.dim = cfg_data[2:1]; end
          default: begin
            for (int i = 0; i < NL; i++) if (cfg_sel == 4'(8 + i)) nsh.key[i] = cfg_data;
          end
        endcase
      end
      if (com) begin
        act  = sh;
        fc   = fc + 16'd1;
        pend = acc;
      end else if (acc) begin
        pend = 1'b1;
      end
      sh = nsh;
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    sh = cfg_default(); act = cfg_default(); pend = 1'b0; fc = '0;
    for (int k = 0; k < 3; k++) begin
      rst_h[k] = 1'b1; cfg_h[k] = cfg_default(); smp_h[k] = '0;
    end
    forever begin
      @(posedge video_clk);
      model_step();
      started = 1'b1;
      @(negedge video_clk);
      chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
      chk("sync_de", 32'({hsync_out, vsync_out, de_out}), 32'(exp_sync));
      chk("commit_pending", 32'(commit_pending), 32'(pend));
      chk("frame_count", 32'(frame_count), 32'(fc));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge video_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] s, input logic [CW-1:0] d);
    cfg_we = 1'b1; cfg_sel = s; cfg_data = d;
    adv(1);
    cfg_we = 1'b0;
  endtask

  task automatic do_commit();
    logic [9:0] h0, v0;
    h0 = hcount; v0 = vcount;
    hcount = 10'd0; vcount = 10'd480;
    adv(1);
    hcount = h0; vcount = v0;
  endtask

  task automatic px_at(input logic [9:0] h, input logic [9:0] v, input logic de,
                       input string name, input logic [CW-1:0] want);
    hcount = h; vcount = v; display_active = de;
    adv(3);
    chk(name, 32'(rgb_out), 32'(want));
  endtask

  function automatic logic [9:0] rnd_h();
    case ($urandom_range(0, 7))
      0:       return 10'd0;
      1:       return 10'd639;
      2:       return 10'($urandom_range(640, 1023));
      default: return 10'($urandom_range(1, 638));
    endcase
  endfunction

  function automatic logic [9:0] rnd_v();
    case ($urandom_range(0, 7))
      0:       return 10'd0;
      1:       return 10'd479;
      2:       return 10'd480;
      3:       return 10'($urandom_range(481, 1023));
      default: return 10'($urandom_range(1, 478));
    endcase
  endfunction

  function automatic logic [CW-1:0] rnd_px();
    if ($urandom_range(0, 3) == 0) return 12'hF00;
    return CW'($urandom);
  endfunction

  initial begin
    msmp_t tsmp;
    mcfg_t tcfg;
    reset = 1'b1; hcount = 10'd5; vcount = 10'd5; hsync_in = 1'b1; vsync_in = 1'b1;
    display_active = 1'b1; layer_rgb = {12'h000, 12'h0F0}; layer_valid = 2'b01;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;

    // Model anchors: dimmed interior pixel and undimmed border pixel
    tcfg = cfg_default(); tcfg.ben = 1'b1; tcfg.dim = 2'd2; tcfg.bc = 12'hFFF;
    tsmp = '0; tsmp.h = 10'd5; tsmp.v = 10'd100; tsmp.de = 1'b1; tsmp.vld = 2'b01;
    tsmp.px[0] = 12'hF84;
    chk("model_dim", 32'(mix(tsmp, tcfg, tcfg, tcfg)), 32'h321);
    tsmp.h = 10'd639;
    chk("model_border", 32'(mix(tsmp, tcfg, tcfg, tcfg)), 32'hFFF);

    // Reset release latency
    adv(2);
    reset = 1'b0;
    adv(1); chk("post_reset_0", 32'(rgb_out), 32'h0);
    adv(1); chk("post_reset_1", 32'(rgb_out), 32'h0);
    adv(1); chk("post_reset_2", 32'(rgb_out), 32'h0F0);
    chk("reset_pending", 32'(commit_pending), 32'h0);

    // Priority, colour key, layer disable
    layer_rgb = {12'hF00, 12'h00F}; layer_valid = 2'b11;
    adv(3); chk("priority", 32'(rgb_out), 32'hF00);
    wr(4'd1, 12'h002);
    chk("pending_after_write", 32'(commit_pending), 32'h1);
    wr(4'd9, 12'hF00);
    do_commit();
    chk("pending_cleared", 32'(commit_pending), 32'h0);
    chk("frame_count_1", 32'(frame_count), 32'h1);
    adv(3); chk("color_key", 32'(rgb_out), 32'h00F);
    wr(4'd2, 12'h123); wr(4'd0, 12'h000);
    do_commit();
    adv(3); chk("bg_fill", 32'(rgb_out), 32'h123);

    // Mid-frame write is held until the frame boundary
    hcount = 10'd5; vcount = 10'd100;
    wr(4'd2, 12'hABC);
    chk("pending_midframe", 32'(commit_pending), 32'h1);
    adv(3); chk("no_tearing", 32'(rgb_out), 32'h123);
    do_commit();
    chk("pending_commit", 32'(commit_pending), 32'h0);
    chk("frame_count_3", 32'(frame_count), 32'h3);
    adv(3); chk("bg_committed", 32'(rgb_out), 32'hABC);

    // Write on the commit cycle lands in the next frame
    hcount = 10'd0; vcount = 10'd480; cfg_we = 1'b1; cfg_sel = 4'd2; cfg_data = 12'h456;
    adv(1);
    cfg_we = 1'b0; hcount = 10'd5; vcount = 10'd100;
    chk("pending_kept", 32'(commit_pending), 32'h1);
    chk("frame_count_4", 32'(frame_count), 32'h4);
    adv(3); chk("late_write_held", 32'(rgb_out), 32'hABC);
    do_commit();
    chk("pending_late_done", 32'(commit_pending), 32'h0);
    adv(3); chk("late_write_applied", 32'(rgb_out), 32'h456);

    // Ignored register selects
    wr(4'd6, 12'hFFF); wr(4'd11, 12'hFFF);
    chk("ignored_sel", 32'(commit_pending), 32'h0);

    // Border and dimming
    wr(4'd0, 12'h003); wr(4'd1, 12'h000);
    layer_valid = 2'b01; layer_rgb = {12'h000, 12'hF84};
    wr(4'd4, 12'h005); wr(4'd3, 12'hFFF);
    do_commit();
    px_at(10'd0,   10'd100, 1'b1, "border_left",   12'hFFF);
    px_at(10'd639, 10'd100, 1'b1, "border_right",  12'hFFF);
    px_at(10'd5,   10'd0,   1'b1, "border_top",    12'hFFF);
    px_at(10'd5,   10'd479, 1'b1, "border_bottom", 12'hFFF);
    px_at(10'd5,   10'd100, 1'b1, "dim_interior",  12'h321);
    px_at(10'd5,   10'd100, 1'b0, "blanked",       12'h000);

    // Continuous commits until frame_count wraps
    hcount = 10'd0; vcount = 10'd480;
    for (int i = 0; i < 70000 && frame_count !== 16'hFFFF; i++) adv(1);
    chk("frame_count_ffff", 32'(frame_count), 32'hFFFF);
    adv(1);
    chk("frame_count_wrap", 32'(frame_count), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset          = ($urandom_range(0, 299) == 0);
      hcount         = rnd_h();
      vcount         = rnd_v();
      hsync_in       = 1'($urandom);
      vsync_in       = 1'($urandom);
      display_active = ($urandom_range(0, 4) != 0);
      layer_rgb      = {rnd_px(), rnd_px()};
      layer_valid    = 2'($urandom);
      cfg_we         = ($urandom_range(0, 3) == 0);
      cfg_sel        = 4'($urandom);
      cfg_data       = ($urandom_range(0, 2) == 0) ? 12'hF00 : CW'($urandom);
      adv(1);
    end
    reset = 1'b0; cfg_we = 1'b0;
    adv(4);

    // Reset mid-line
    hcount = 10'd300; vcount = 10'd100; display_active = 1'b1;
    wr(4'd2, 12'h777);
    reset = 1'b1;
    adv(1);
    chk("midline_rgb", 32'(rgb_out), 32'h0);
    chk("midline_sync_de", 32'({hsync_out, vsync_out, de_out}), 32'b110);
    chk("midline_pending", 32'(commit_pending), 32'h0);
    chk("midline_frames", 32'(frame_count), 32'h0);
    reset = 1'b0;
    adv(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
